iter_shift_extend_unit: RTL and testbench

- Multi-cycle shift/extend unit for the multicycle datapath.
- Replaces the fixed `<<2` shifter and 16-to-32 sign extender.
- Adds runtime-selected logical/arithmetic shifts by a variable amount, performed STEP bits per cycle, plus single-cycle zero/sign extension, branch-offset and LUI forms.
- Start/busy/done handshake, driven by the control FSM.

---
 rtl/iter_shift_extend_unit_pkg.sv | 31 +++
 rtl/iter_shift_extend_unit_shift_step.sv | 26 ++
 rtl/iter_shift_extend_unit.sv | 132 +++++++++++++
 tb/tb_iter_shift_extend_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/iter_shift_extend_unit_pkg.sv
// Shared definitions for the iterative shift/extend unit: op codes, FSM states, helpers.
// Optional rotate support is selected in the top with macro ISE_ROTATE_EN.
package iter_shift_extend_unit_pkg;

    localparam logic [2:0] OP_SLL       = 3'b000;
    localparam logic [2:0] OP_SRL       = 3'b001;
    localparam logic [2:0] OP_SRA       = 3'b010;
    localparam logic [2:0] OP_ROR       = 3'b011;
    localparam logic [2:0] OP_SEXT      = 3'b100;
    localparam logic [2:0] OP_ZEXT      = 3'b101;
    localparam logic [2:0] OP_SEXT_SHL2 = 3'b110;
    localparam logic [2:0] OP_LUI       = 3'b111;

    localparam int DEF_WIDTH = 32;
    localparam int SHAMT_W   = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/iter_shift_extend_unit_shift_step.sv
// Combinational single step: shifts or rotates the operand by k bits for the given op.
// Rotate is only meaningful when the top is built with ISE_ROTATE_EN.
module iter_shift_extend_unit_shift_step
    import iter_shift_extend_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]               i_op,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_k,
    output logic [WIDTH-1:0]         o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = i_data << i_k;
            OP_SRL:  o_data = i_data >> i_k;
            OP_SRA:  o_data = $unsigned($signed(i_data) >>> i_k);
            // A zero-bit step makes the left term shift out entirely, leaving i_data.
            OP_ROR:  o_data = (i_data >> i_k) | (i_data << (WIDTH - int'(i_k)));
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/iter_shift_extend_unit.sv
// Multi-cycle shift/extend unit with start/busy/done handshake; shifts advance STEP bits per cycle.
// Define ISE_ROTATE_EN to enable op 011 as iterative rotate-right; otherwise it returns 0.
module iter_shift_extend_unit
    import iter_shift_extend_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int STEP      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [IMM_WIDTH-1:0]     imm_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result
);

    localparam int SW = $clog2(WIDTH);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [SW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_is_iter;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_zext;
    logic [WIDTH-1:0] w_single;
    logic [SW-1:0]    w_k;
    logic [WIDTH-1:0] w_step_out;

    assign w_sext = WIDTH'($signed(imm_in));
    assign w_zext = WIDTH'(imm_in);
    assign w_k    = SW'(min_int(STEP, int'(r_count)));

    always_comb begin
        w_is_iter = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: w_is_iter = 1'b1;
`ifdef ISE_ROTATE_EN
            OP_ROR:                 w_is_iter = 1'b1;
`endif
            default:                w_is_iter = 1'b0;
        endcase
    end

    // Result for everything that finishes on the accepting edge, including zero-amount shifts.
    always_comb begin
        w_single = '0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: w_single = data_in;
`ifdef ISE_ROTATE_EN
            OP_ROR:                 w_single = data_in;
`else
            OP_ROR:                 w_single = '0;
`endif
            OP_SEXT:                w_single = w_sext;
            OP_ZEXT:                w_single = w_zext;
            OP_SEXT_SHL2:           w_single = w_sext << 2;
            OP_LUI:                 w_single = w_zext << (WIDTH - IMM_WIDTH);
            default:                w_single = '0;
        endcase
    end

    iter_shift_extend_unit_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_op   (r_op),
        .i_data (r_result),
        .i_k    (w_k),
        .o_data (w_step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_SLL;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_op <= op;
                        if (w_is_iter && (shamt != '0)) begin
                            r_result <= data_in;
                            r_count  <= shamt;
                            r_busy   <= 1'b1;
                            r_state  <= ST_SHIFT;
                        end else begin
                            r_result <= w_single;
                            r_count  <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_step_out;
                    r_count  <= r_count - w_k;
                    // The last partial step lands the unit directly in DONE.
                    if (r_count == w_k) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_iter_shift_extend_unit.sv
// Directed bench for iter_shift_extend_unit: one STEP=1 and one STEP=3 instance.
// Rotate expectations follow ISE_ROTATE_EN.
module tb_iter_shift_extend_unit;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start3;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [15:0] imm_in;
    logic [4:0]  shamt;
    logic        busy1, done1, busy3, done3;
    logic [31:0] result1, result3;

    int total = 0;
    int bad   = 0;

    iter_shift_extend_unit #(.WIDTH(32), .IMM_WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .data_in(data_in),
        .imm_in(imm_in), .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
    );

    iter_shift_extend_unit #(.WIDTH(32), .IMM_WIDTH(16), .STEP(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op(op), .data_in(data_in),
        .imm_in(imm_in), .shamt(shamt), .busy(busy3), .done(done3), .result(result3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble inputs after the accept edge, then count edges until done.
    task automatic run(input bit sel3, input logic [2:0] o, input logic [31:0] d,
                       input logic [15:0] im, input logic [4:0] sh,
                       output int edges, output int busy_cyc);
        op = o; data_in = d; imm_in = im; shamt = sh;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        data_in = ~d; imm_in = ~im; shamt = ~sh; op = ~o;
        edges = 1; busy_cyc = 0;
        while (!(sel3 ? done3 : done1) && edges < 100) begin
            if (sel3 ? busy3 : busy1) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        op = 3'b000; data_in = '0; imm_in = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (result1 !== 32'h0) begin bad++; $display("FAIL reset_result1 got=%h exp=%h", result1, 32'h0); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b exp=0", done1); end
        total++; if (result3 !== 32'h0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            bad++; $display("FAIL reset_dut3 got=%h/%b/%b exp=0/0/0", result3, busy3, done3);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_extend();
        int e, b;
        run(1'b0, 3'b100, 32'h0, 16'h9FFF, 5'd0, e, b);
        total++; if (result1 !== 32'hFFFF_9FFF) begin bad++; $display("FAIL sext_result got=%h exp=%h", result1, 32'hFFFF_9FFF); end
        total++; if (e !== 1) begin bad++; $display("FAIL sext_latency got=%0d exp=1", e); end
        total++; if (b !== 0) begin bad++; $display("FAIL sext_busy got=%0d exp=0", b); end
        run(1'b0, 3'b101, 32'h0, 16'h9FFF, 5'd0, e, b);
        total++; if (result1 !== 32'h0000_9FFF) begin bad++; $display("FAIL zext_result got=%h exp=%h", result1, 32'h0000_9FFF); end
    endtask

    task automatic test_branch_lui();
        int e, b;
        run(1'b0, 3'b110, 32'h0, 16'h8001, 5'd0, e, b);
        total++; if (result1 !== 32'hFFFE_0004) begin bad++; $display("FAIL sext_shl2 got=%h exp=%h", result1, 32'hFFFE_0004); end
        run(1'b0, 3'b111, 32'h0, 16'h1234, 5'd0, e, b);
        total++; if (result1 !== 32'h1234_0000) begin bad++; $display("FAIL lui got=%h exp=%h", result1, 32'h1234_0000); end
        total++; if (e !== 1) begin bad++; $display("FAIL lui_latency got=%0d exp=1", e); end
    endtask

    task automatic test_shift_step1();
        int e, b;
        run(1'b0, 3'b010, 32'h8000_00F0, 16'h0, 5'd4, e, b);
        total++; if (result1 !== 32'hF800_000F) begin bad++; $display("FAIL sra_result got=%h exp=%h", result1, 32'hF800_000F); end
        total++; if (e !== 5) begin bad++; $display("FAIL sra_latency got=%0d exp=5", e); end
        total++; if (b !== 4) begin bad++; $display("FAIL sra_busy got=%0d exp=4", b); end
        run(1'b0, 3'b001, 32'h8000_00F0, 16'h0, 5'd4, e, b);
        total++; if (result1 !== 32'h0800_000F) begin bad++; $display("FAIL srl_result got=%h exp=%h", result1, 32'h0800_000F); end
        run(1'b0, 3'b000, 32'h0000_0001, 16'h0, 5'd31, e, b);
        total++; if (result1 !== 32'h8000_0000) begin bad++; $display("FAIL sll31_result got=%h exp=%h", result1, 32'h8000_0000); end
        total++; if (e !== 32) begin bad++; $display("FAIL sll31_latency got=%0d exp=32", e); end
    endtask

    task automatic test_remainder();
        int e, b;
        run(1'b1, 3'b000, 32'h0000_0001, 16'h0, 5'd7, e, b);
        total++; if (result3 !== 32'h0000_0080) begin bad++; $display("FAIL step3_result got=%h exp=%h", result3, 32'h0000_0080); end
        total++; if (e !== 4) begin bad++; $display("FAIL step3_latency got=%0d exp=4", e); end
        total++; if (b !== 3) begin bad++; $display("FAIL step3_busy got=%0d exp=3", b); end
        run(1'b1, 3'b010, 32'h8000_0000, 16'h0, 5'd5, e, b);
        total++; if (result3 !== 32'hFC00_0000) begin bad++; $display("FAIL step3_sra got=%h exp=%h", result3, 32'hFC00_0000); end
        run(1'b1, 3'b001, 32'h1234_5678, 16'h0, 5'd0, e, b);
        total++; if (result3 !== 32'h1234_5678) begin bad++; $display("FAIL shamt0_result got=%h exp=%h", result3, 32'h1234_5678); end
        total++; if (e !== 1) begin bad++; $display("FAIL shamt0_latency got=%0d exp=1", e); end
    endtask

    task automatic test_ignore_start();
        int e;
        op = 3'b001; data_in = 32'hF000_0000; shamt = 5'd8; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; data_in = 32'h0;
        @(posedge clk); #1;
        op = 3'b000; data_in = 32'hFFFF_FFFF; shamt = 5'd1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        e = 3;
        while (!done1 && e < 100) begin
            @(posedge clk); #1;
            e++;
        end
        total++; if (result1 !== 32'h00F0_0000) begin bad++; $display("FAIL ignore_result got=%h exp=%h", result1, 32'h00F0_0000); end
        total++; if (e !== 9) begin bad++; $display("FAIL ignore_latency got=%0d exp=9", e); end
        @(posedge clk); #1;
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done1); end
        total++; if (result1 !== 32'h00F0_0000) begin bad++; $display("FAIL result_hold got=%h exp=%h", result1, 32'h00F0_0000); end
    endtask

    task automatic test_back_to_back();
        op = 3'b100; imm_in = 16'h0001; start1 = 1'b1;
        @(posedge clk); #1;
        total++; if (done1 !== 1'b1 || result1 !== 32'h0000_0001) begin
            bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", done1, result1, 32'h0000_0001);
        end
        imm_in = 16'hFFFF;
        @(posedge clk); #1;
        start1 = 1'b0;
        total++; if (done1 !== 1'b1 || result1 !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL b2b_second got=%b/%h exp=1/%h", done1, result1, 32'hFFFF_FFFF);
        end
        @(posedge clk); #1;
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", done1); end
    endtask

    task automatic test_reset_mid();
        op = 3'b000; data_in = 32'h0000_0001; shamt = 5'd20; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy1); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (result1 !== 32'h0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%h/%b exp=0/0", result1, busy1);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        total++; if (done1 !== 1'b0 || busy1 !== 1'b0 || result1 !== 32'h0) begin
            bad++; $display("FAIL mid_discard got=%b/%b/%h exp=0/0/0", done1, busy1, result1);
        end
    endtask

    task automatic test_rotate();
        int e, b;
        run(1'b0, 3'b011, 32'h0000_000F, 16'h0, 5'd4, e, b);
`ifdef ISE_ROTATE_EN
        total++; if (result1 !== 32'hF000_0000) begin bad++; $display("FAIL ror_result got=%h exp=%h", result1, 32'hF000_0000); end
        total++; if (e !== 5) begin bad++; $display("FAIL ror_latency got=%0d exp=5", e); end
`else
        total++; if (result1 !== 32'h0) begin bad++; $display("FAIL ror_off_result got=%h exp=%h", result1, 32'h0); end
        total++; if (e !== 1 || b !== 0) begin bad++; $display("FAIL ror_off_latency got=%0d/%0d exp=1/0", e, b); end
`endif
    endtask

    initial begin
        test_reset();
        test_extend();
        test_branch_lui();
        test_shift_step1();
        test_remainder();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_rotate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
